// File: rtl/mp4_ctrl_pkg.sv
// mp4_ctrl_pkg: shared state, opcode, ALU and mux-select encodings for the multicycle RV32I controller
// Exports state_t, ctrl_t and decode(), which maps a state to its Moore control word.
package mp4_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_SLT = 3'b101;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic adr_src;
    logic ir_write;
    logic pc_update;
    logic branch;
    logic reg_write;
    logic mem_write;
  } ctrl_t;
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1;
        c.src_a = SRCA_PC;
        c.src_b = SRCB_FOUR;
        c.result_src = RES_ALU;
        c.pc_update = 1'b1;
      end
      S_DECODE: begin
        c.src_a = SRCA_OLDPC;
        c.src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_RS2;
        c.alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
        c.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_RS2;
        c.alu_op = ALUOP_SUB;
        c.branch = 1'b1;
      end
      S_JAL: begin
        c.src_a = SRCA_OLDPC;
        c.src_b = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and Zero in, control word out, between controller and datapath
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5;
  logic Zero;
  logic [2:0] ALU_control;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic AdrSrc;
  logic IRWrite;
  logic PCWrite;
  logic RegWrite;
  logic MemWrite;
  logic illegal_op;
  modport master (
    input op, funct3, funct7b5, Zero,
    output ALU_control, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
    output IRWrite, PCWrite, RegWrite, MemWrite, illegal_op
  );
  modport slave (
    output op, funct3, funct7b5, Zero,
    input ALU_control, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
    input IRWrite, PCWrite, RegWrite, MemWrite, illegal_op
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp, funct3, op[5] and funct7b5 to ALU_control
// In: alu_op[1:0], funct3[2:0], op5, funct7b5. Out: ALU_control[2:0].
module alu_decoder
  import mp4_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALU_control
);
  always_comb begin
    ALU_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  funct3 == 3'b000    ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010    ? ALU_SLT :
                  funct3 == 3'b110    ? ALU_OR :
                  funct3 == 3'b111    ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing fetch/decode/execute/memory/writeback for a multicycle RV32I core
// Ports: clk, rst_n (async, active low), bus (multicycle_controller_if.master).
// Param MEM_WAIT_CYCLES (0-15): extra MEMREAD cycles. Macro BRANCH_NE_EN: BEQ state also handles bne.
module multicycle_controller
  import mp4_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 0
) (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] WAIT = 4'(MEM_WAIT_CYCLES);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, take;
  ctrl_t ctl_q, ctl_d;
  always_comb begin
    state_d = S_FETCH;
    cnt_d = '0;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: state_d = S_EXECUTER;
          OP_I: state_d = S_EXECUTEI;
          OP_BEQ: state_d = S_BEQ;
          OP_JAL: state_d = S_JAL;
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEMADR: state_d = bus.op == OP_SW ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        state_d = cnt_q == WAIT ? S_MEMWB : S_MEMREAD;
        cnt_d = cnt_q + 4'd1;
      end
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      default: state_d = S_FETCH;
    endcase
    // outputs are registered: decode the state being entered
    ctl_d = decode(state_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
      illegal_q <= 1'b0;
      ctl_q <= decode(S_FETCH);
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      ctl_q <= ctl_d;
    end
  end
`ifdef BRANCH_NE_EN
  assign take = bus.funct3[0] ? ~bus.Zero : bus.Zero;
`else
  assign take = bus.Zero;
`endif
  alu_decoder u_alu_dec (
    .alu_op(ctl_q.alu_op),
    .funct3(bus.funct3),
    .op5(bus.op[5]),
    .funct7b5(bus.funct7b5),
    .ALU_control(bus.ALU_control)
  );
  assign bus.ImmSrc = bus.op == OP_SW  ? 2'b01 :
                      bus.op == OP_BEQ ? 2'b10 :
                      bus.op == OP_JAL ? 2'b11 : 2'b00;
  assign bus.ALUSrcA = ctl_q.src_a;
  assign bus.ALUSrcB = ctl_q.src_b;
  assign bus.ResultSrc = ctl_q.result_src;
  assign bus.AdrSrc = ctl_q.adr_src;
  // the reset value holds FETCH's enables, so gate them while reset is asserted
  assign bus.IRWrite = rst_n & ctl_q.ir_write;
  assign bus.PCWrite = rst_n & (ctl_q.pc_update | (ctl_q.branch & take));
  assign bus.RegWrite = rst_n & ctl_q.reg_write;
  assign bus.MemWrite = rst_n & ctl_q.mem_write;
  assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller with MEM_WAIT_CYCLES=2
module tb_multicycle_controller;
  localparam int W = 2;
  typedef struct {
    string tag;
    logic [16:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [1:0] imm_e;
  logic ill_e = 1'b0;
  multicycle_controller_if ifc ();
  multicycle_controller #(.MEM_WAIT_CYCLES(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  always #5 clk = ~clk;
  wire [16:0] obs = {ifc.illegal_op, ifc.IRWrite, ifc.PCWrite, ifc.RegWrite, ifc.MemWrite,
                     ifc.AdrSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ResultSrc, ifc.ImmSrc, ifc.ALU_control};
  task automatic put(string tag, logic irw, logic pcw, logic rw, logic mw, logic adr,
                     logic [1:0] a, logic [1:0] b, logic [1:0] res, logic [2:0] alu);
    exp_t e;
    e.tag = tag;
    e.v = {ill_e, irw, pcw, rw, mw, adr, a, b, res, imm_e, alu};
    q.push_back(e);
  endtask
  task automatic check_one();
    exp_t e;
    #1;
    e = q.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", e.tag, obs, e.v);
    end
  endtask
  task automatic drain(int keep);
    while (q.size() > keep) begin
      check_one();
      @(negedge clk);
    end
  endtask
  task automatic load(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                      logic [2:0] alu, logic br);
    ifc.op = o;
    ifc.funct3 = f3;
    ifc.funct7b5 = f7;
    ifc.Zero = z;
    imm_e = o == 7'b0100011 ? 2'b01 : o == 7'b1100011 ? 2'b10 : o == 7'b1101111 ? 2'b11 : 2'b00;
    put({nm, ":FETCH"}, 1, 1, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'b000);
    put({nm, ":DECODE"}, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'b000);
    case (o)
      7'b0000011: begin
        put({nm, ":MEMADR"}, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'b000);
        repeat (W + 1) put({nm, ":MEMREAD"}, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'b000);
        put({nm, ":MEMWB"}, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd1, 3'b000);
      end
      7'b0100011: begin
        put({nm, ":MEMADR"}, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'b000);
        put({nm, ":MEMWRITE"}, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 3'b000);
      end
      7'b0110011: begin
        put({nm, ":EXECUTER"}, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, alu);
        put({nm, ":ALUWB"}, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'b000);
      end
      7'b0010011: begin
        put({nm, ":EXECUTEI"}, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, alu);
        put({nm, ":ALUWB"}, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'b000);
      end
      7'b1100011: put({nm, ":BEQ"}, 0, br, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'b001);
      7'b1101111: begin
        put({nm, ":JAL"}, 0, 1, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'b000);
        put({nm, ":ALUWB"}, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'b000);
      end
      default: ill_e = 1'b1;
    endcase
  endtask
  task automatic instr(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                       logic [2:0] alu, logic br);
    load(nm, o, f3, f7, z, alu, br);
    drain(0);
  endtask
  initial begin
    ifc.op = 7'b0;
    ifc.funct3 = 3'b0;
    ifc.funct7b5 = 1'b0;
    ifc.Zero = 1'b0;
    #1;
    checks++;
    assert ({ifc.IRWrite, ifc.PCWrite, ifc.RegWrite, ifc.MemWrite, ifc.illegal_op} === 5'b0) else begin
      errors++;
      $error("FAIL reset_hold observed %b expected 00000",
             {ifc.IRWrite, ifc.PCWrite, ifc.RegWrite, ifc.MemWrite, ifc.illegal_op});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0);
    instr("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011, 1'b0);
    instr("and", 7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 1'b0);
    instr("slt", 7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, 1'b0);
    instr("sll", 7'b0110011, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0);
    instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0);
    instr("ori", 7'b0010011, 3'b110, 1'b0, 1'b0, 3'b011, 1'b0);
    instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0);
    instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0);
    instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1);
    instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0);
`ifdef BRANCH_NE_EN
    instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1);
    instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 3'b001, 1'b0);
`else
    instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 3'b001, 1'b0);
    instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 3'b001, 1'b1);
`endif
    instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    instr("bad", 7'b1111111, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    instr("add_ill", 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    load("lw_rst", 7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0);
    drain(1);
    check_one();
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({ifc.IRWrite, ifc.PCWrite, ifc.RegWrite, ifc.MemWrite, ifc.illegal_op} === 5'b0) else begin
      errors++;
      $error("FAIL reset_memwb observed %b expected 00000",
             {ifc.IRWrite, ifc.PCWrite, ifc.RegWrite, ifc.MemWrite, ifc.illegal_op});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ill_e = 1'b0;
    instr("add_post", 7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I core; sits directly upstream of the ALU.
- Decodes the latched instruction fields and sequences fetch, decode, execute, memory and writeback.
- Drives the ALU operation code and the datapath mux selects and write enables, and consumes the ALU Zero flag for branches.
- One instruction in flight, no pipelining.

Parameters:
- MEM_WAIT_CYCLES, 0: extra cycles MEMREAD holds before MEMWB (slow data memory); range 0-15.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instruction[6:0] from instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- Zero  in  1  ALU zero flag (ALU_result == 0)
- ALU_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 reg
- ALUSrcB  out  2  00 rs2 reg, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU_result
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; combinational from op
- AdrSrc  out  1  0 PC, 1 Result
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write enables
- illegal_op  out  1  sticky flag for an unsupported opcode

Behaviour:
- Reset: rst_n low forces state to FETCH, wait counter to 0 and illegal_op to 0 asynchronously. While rst_n is low, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
- All other outputs are Moore outputs decoded from state. The only exceptions are PCWrite = PCUpdate | (Branch & Zero), and ImmSrc/ALU_control, which are combinational from the instruction fields.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Unlisted outputs in each state are 0.
- FETCH: AdrSrc=0, IRWrite=1, SrcA=PC, SrcB=4, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
- DECODE: SrcA=OldPC, SrcB=Imm, ALUOp=00 (branch target into ALUOut). Next state by op:
  - lw/sw -> MEMADR
  - R -> EXECUTER
  - I-ALU -> EXECUTEI
  - beq -> BEQ
  - jal -> JAL
  - any other op -> FETCH, and set illegal_op.
- MEMADR: SrcA=rs1, SrcB=Imm, ALUOp=00 -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: ResultSrc=00, AdrSrc=1. Holds MEM_WAIT_CYCLES extra cycles, counting on a 4-bit counter cleared on entry, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
- EXECUTER: SrcA=rs1, SrcB=rs2, ALUOp=10 -> ALUWB.
- EXECUTEI: SrcA=rs1, SrcB=Imm, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: SrcA=rs1, SrcB=rs2, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH. PCWrite equals Zero in this cycle.
- JAL: SrcA=OldPC, SrcB=4, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- ALU decode:
  - ALUOp 00 -> ADD; 01 -> SUB.
  - ALUOp 10, funct3=000: SUB if op[5]&funct7b5, else ADD.
  - ALUOp 10, funct3 010 -> SLT, 110 -> OR, 111 -> AND.
  - ALUOp 10, any other funct3 -> ADD; illegal_op is not set.
- CPI: lw 5+MEM_WAIT_CYCLES; sw, R, I-ALU and jal 4; beq 3.
- Reset mid-instruction aborts it; the next cycle after release is FETCH.
- illegal_op clears only on reset.
- No unreachable state may hang: an undefined encoding goes to FETCH.

Optional Feature:
- BRANCH_NE_EN. When defined, BEQ state also serves bne (op 1100011, funct3 001), and PCWrite = Branch & (funct3[0] ? ~Zero : Zero).
- When not defined, funct3 is ignored in BEQ; bne behaves as beq.

Decomposition:
- Package mp4_ctrl_pkg holds:
  - state enum
  - opcode localparams
  - ALU_control encodings (ADD 000, SUB 001, AND 010, OR 011, SLT 101), shared with the ALU
  - ALUSrcA/ALUSrcB/ResultSrc encodings
- Sub-module alu_decoder: combinational ALUOp, funct3, op[5], funct7b5 -> ALU_control.

Test Plan:
- Reset: hold rst_n=0 mid-MEMWB (RegWrite high) -> all write enables 0 immediately; after release, first cycle is FETCH with IRWrite=1.
- add (op 0110011, f3 000, f7b5 0) -> FETCH, DECODE, EXECUTER (ALU_control 000), ALUWB (RegWrite=1); sub (f7b5=1) -> 001 in EXECUTER.
- lw with MEM_WAIT_CYCLES=2 -> MEMREAD held 3 cycles, AdrSrc=1; MEMWB RegWrite=1, ResultSrc=01; total 7 cycles.
- beq with Zero=1 -> PCWrite=1 in the BEQ cycle, ALU_control=001; with Zero=0 -> PCWrite=0; 3 cycles each.
- op 1111111 -> DECODE -> FETCH, illegal_op=1 and stays 1 through a following add.
- BRANCH_NE_EN defined, bne (f3 001) with Zero=0 -> PCWrite=1; with Zero=1 -> PCWrite=0.
